// File: rtl/readout_sequencer.sv
// Event sequencer above the merge readout: paces events, times readout windows,
// and reports per-event word counts with overrun flagging.
module readout_sequencer #(
  parameter int PERIOD  = 100,
  parameter int HOLDOFF = 3,
  parameter int DRAIN   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       done,
  input  logic       valid,
  output logic       start_evt,
  output logic [2:0] BX,
  output logic [6:0] clk_cnt,
  output logic [2:0] BX_pipe,
  output logic       busy,
  output logic [9:0] evt_words,
  output logic       evt_trunc,
  output logic       evt_vld,
  output logic [7:0] overrun_cnt
);

  localparam logic [6:0] CNT_LAST = 7'(PERIOD - 1);
  localparam logic [6:0] HO_LAST  = 7'(HOLDOFF - 1);
  localparam logic [6:0] DR_LAST  = 7'(DRAIN - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_REPORT, S_WAIT} state_t;

  state_t     state, state_nxt;
  logic       running, running_nxt;
  logic [6:0] cnt_nxt;
  logic [2:0] bx_nxt;
  logic       start_nxt;
  logic [6:0] tmr, tmr_nxt;
  logic [9:0] wcnt, wcnt_nxt, wsum;
  logic       rpt, trunc, ovr, count_en;

  // Slot counter: next values are computed so start_evt lands with clk_cnt==0.
  always_comb begin
    running_nxt = running;
    cnt_nxt     = clk_cnt;
    bx_nxt      = BX;
    if (!running) begin
      cnt_nxt = '0;
      if (enable) running_nxt = 1'b1;
    end else if (clk_cnt == CNT_LAST) begin
      cnt_nxt     = '0;
      bx_nxt      = BX + 3'd1;
      running_nxt = enable;
    end else begin
      cnt_nxt = clk_cnt + 7'd1;
    end
    start_nxt = running_nxt && (cnt_nxt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running   <= 1'b0;
      clk_cnt   <= '0;
      BX        <= '0;
      BX_pipe   <= '0;
      start_evt <= 1'b0;
    end else begin
      running   <= running_nxt;
      clk_cnt   <= cnt_nxt;
      BX        <= bx_nxt;
      start_evt <= start_nxt;
      if (start_nxt) BX_pipe <= BX;
    end
  end

  assign count_en = (state == S_RUN || state == S_DRAIN) && valid;
  assign wsum     = (count_en && wcnt != 10'h3FF) ? wcnt + 10'd1 : wcnt;

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    wcnt_nxt  = wcnt;
    rpt       = 1'b0;
    trunc     = 1'b0;
    ovr       = 1'b0;
    case (state)
      S_IDLE, S_WAIT, S_REPORT: begin
        if (start_evt) begin
          state_nxt = S_SETUP;
          tmr_nxt   = '0;
          wcnt_nxt  = '0;
        end else if (state == S_REPORT) begin
          state_nxt = running ? S_WAIT : S_IDLE;
        end else if (!running) begin
          state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (tmr == HO_LAST) state_nxt = S_RUN;
        else                tmr_nxt   = tmr + 7'd1;
      end
      S_RUN: begin
        wcnt_nxt = wsum;
        if (done) begin
          state_nxt = S_DRAIN;
          tmr_nxt   = '0;
        end
      end
      S_DRAIN: begin
        wcnt_nxt = wsum;
        if (tmr == DR_LAST) begin
          state_nxt = S_REPORT;
          rpt       = 1'b1;
        end else begin
          tmr_nxt = tmr + 7'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A new event arriving mid-readout truncates the current one.
    if (start_evt && (state == S_SETUP || state == S_RUN || state == S_DRAIN)) begin
      state_nxt = S_SETUP;
      tmr_nxt   = '0;
      wcnt_nxt  = '0;
      rpt       = 1'b1;
      trunc     = 1'b1;
      ovr       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      tmr         <= '0;
      wcnt        <= '0;
      busy        <= 1'b0;
      evt_words   <= '0;
      evt_trunc   <= 1'b0;
      evt_vld     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      wcnt    <= wcnt_nxt;
      busy    <= (state_nxt == S_SETUP || state_nxt == S_RUN || state_nxt == S_DRAIN);
      evt_vld <= rpt;
      if (rpt) begin
        evt_words <= wsum;
        evt_trunc <= trunc;
      end
      if (ovr && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// Randomized scoreboard bench for readout_sequencer: the driver plans each event's
// valid/done pattern and queues the expected report, a monitor pops and compares.
module tb_readout_sequencer;
  localparam int PERIOD  = 100;
  localparam int HOLDOFF = 3;
  localparam int DRAIN   = 2;

  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, done = 1'b0, valid = 1'b0;
  logic       start_evt, busy, evt_trunc, evt_vld;
  logic [2:0] BX, BX_pipe;
  logic [6:0] clk_cnt;
  logic [9:0] evt_words;
  logic [7:0] overrun_cnt;

  readout_sequencer #(.PERIOD(PERIOD), .HOLDOFF(HOLDOFF), .DRAIN(DRAIN)) dut (
    .clk(clk), .reset(reset), .enable(enable), .done(done), .valid(valid),
    .start_evt(start_evt), .BX(BX), .clk_cnt(clk_cnt), .BX_pipe(BX_pipe),
    .busy(busy), .evt_words(evt_words), .evt_trunc(evt_trunc), .evt_vld(evt_vld),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int words;
    int trunc;
    int ovr;
    int at;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   ovr_model = 0;
  bit   no_start = 1'b0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_start_evt"},   int'(start_evt),   0);
    chk({tag, "_BX"},          int'(BX),          0);
    chk({tag, "_clk_cnt"},     int'(clk_cnt),     0);
    chk({tag, "_BX_pipe"},     int'(BX_pipe),     0);
    chk({tag, "_busy"},        int'(busy),        0);
    chk({tag, "_evt_words"},   int'(evt_words),   0);
    chk({tag, "_evt_trunc"},   int'(evt_trunc),   0);
    chk({tag, "_evt_vld"},     int'(evt_vld),     0);
    chk({tag, "_overrun_cnt"}, int'(overrun_cnt), 0);
  endtask

  // Monitor: slot bookkeeping at every start, report contents at every evt_vld.
  initial begin : mon
    int   nstart;
    int   last;
    exp_t e;
    nstart = 0;
    last   = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        nstart = 0;
        q.delete();
        continue;
      end
      if (no_start) chk("start_after_disable", int'(start_evt), 0);
      if (nstart > 0 && cyc - last < PERIOD) chk("clk_cnt", int'(clk_cnt), cyc - last);
      if (start_evt) begin
        chk("start_clk_cnt", int'(clk_cnt), 0);
        if (nstart > 0) chk("start_spacing", cyc - last, PERIOD);
        chk("BX", int'(BX), nstart % 8);
        chk("BX_pipe", int'(BX_pipe), (nstart == 0) ? 0 : (nstart - 1) % 8);
        last = cyc;
        nstart++;
      end
      if (q.size() > 0 && cyc > q[0].at) begin
        chk("evt_vld_missing_at", cyc, q[0].at);
        e = q.pop_front();
      end
      if (evt_vld) begin
        chk("evt_vld_pending", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("evt_cycle",   cyc,               e.at);
          chk("evt_words",   int'(evt_words),   e.words);
          chk("evt_trunc",   int'(evt_trunc),   e.trunc);
          chk("overrun_cnt", int'(overrun_cnt), e.ovr);
        end
      end
    end
  end

  // kind: 0 random, 1 five beats + done, 2 setup beat + 3 run beats,
  // 3 forty beats no done, 4 drain edge, 5 empty overrun, 6 reset mid-run,
  // 7 normal event with enable dropped mid-event
  task automatic run_event(input int kind);
    bit   vp[PERIOD];
    int   dd, t, n, lim, words;
    exp_t e;
    n = 0;
    while (!start_evt && n < 2 * PERIOD + 2) begin
      @(posedge clk); #1;
      n++;
    end
    if (!start_evt) begin
      chk("start_timeout", int'(start_evt), 1);
      return;
    end
    t = cyc;
    foreach (vp[i]) vp[i] = 1'b0;
    dd = -1;
    case (kind)
      1: begin for (int i = 4; i <= 8; i++) vp[i] = 1'b1; dd = 10; end
      2: begin vp[2] = 1'b1; vp[5] = 1'b1; vp[6] = 1'b1; vp[9] = 1'b1; dd = 12; end
      3: for (int i = 10; i <= 49; i++) vp[i] = 1'b1;
      4: begin for (int i = 19; i <= 23; i++) vp[i] = 1'b1; dd = 20; end
      5: dd = -1;
      6: for (int i = 4; i <= 30; i++) vp[i] = 1'b1;
      default: begin
        if (kind == 7) dd = 30;
        else if ($urandom_range(1, 0) == 1) dd = $urandom_range(PERIOD - DRAIN - 3, HOLDOFF + 1);
        for (int i = 1; i < PERIOD; i++) vp[i] = ($urandom_range(2, 0) == 0);
      end
    endcase
    if (kind != 6) begin
      lim   = (dd >= 0) ? dd + DRAIN : PERIOD - 1;
      words = 0;
      for (int i = HOLDOFF + 1; i <= lim; i++) if (vp[i]) words++;
      e.words = words;
      e.trunc = (dd < 0) ? 1 : 0;
      if (dd < 0 && ovr_model < 255) ovr_model++;
      e.ovr = ovr_model;
      e.at  = (dd >= 0) ? t + dd + DRAIN + 1 : t + PERIOD + 1;
      q.push_back(e);
    end
    for (int o = 0; o < PERIOD; o++) begin
      if (o > 0) begin @(posedge clk); #1; end
      if (kind == 6 && o == 20) begin
        reset = 1'b1;
        valid = 1'b0;
        done  = 1'b0;
        ovr_model = 0;
        #1;
        check_zero("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold_evt_vld", int'(evt_vld), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("restart_start_evt", int'(start_evt), 1);
        chk("restart_BX", int'(BX), 0);
        return;
      end
      if (kind == 7 && o == 50) enable = 1'b0;
      valid = vp[o];
      done  = (o == dd);
    end
  endtask

  initial begin : main
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset  = 1'b0;
    enable = 1'b1;
    run_event(1);
    run_event(2);
    run_event(3);
    run_event(4);
    for (int k = 0; k < 20; k++) run_event(0);
    for (int k = 0; k < 300; k++) run_event(5);
    chk("overrun_saturated", int'(overrun_cnt), 255);
    run_event(6);
    run_event(1);
    for (int k = 0; k < 3; k++) run_event(0);
    run_event(7);
    valid = 1'b0;
    done  = 1'b0;
    @(posedge clk); #1;
    no_start = 1'b1;
    repeat (3 * PERIOD) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_clk_cnt", int'(clk_cnt), 0);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
